// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : Byte-to-frame sequencer between UART receiver and frame assembler;
//            pads stalled frames, holds completed frames for a valid/ready
//            consumer. Optional drop counter: UART_FRAME_CTRL_DROP_CNT_EN.
// Revision : 1.0
// ============================================================================
module uart_rx_frame_ctrl #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter int               TIMEOUT  = 1000,
  parameter logic [WIDTH-1:0] PAD_BYTE = '0,
  parameter int               DROP_W   = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rx_valid,
  input  logic [WIDTH-1:0]  rx_data,
  output logic              asm_push,
  output logic [WIDTH-1:0]  asm_data,
  input  logic              asm_valid,
  output logic              frame_valid,
  output logic              frame_err,
  input  logic              frame_ready,
  output logic              busy,
  output logic              sync_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_PAD      = 3'd2,
    S_WAIT_ASM = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  // A single-byte frame is complete as soon as its first byte is accepted.
  localparam state_t ACCEPT_ST = (DEPTH == 1) ? S_WAIT_ASM : S_COLLECT;

  state_t            state, state_nxt;
  logic [CW-1:0]     byte_cnt, byte_cnt_nxt, cnt_inc;
  logic [TW-1:0]     timer, timer_nxt, timer_inc;
  logic              err_flag, err_flag_nxt;
  logic              wait_cnt, wait_cnt_nxt;
  logic              push_nxt;
  logic [WIDTH-1:0]  data_nxt;
  logic              sync_set;
  logic              drop;

  assign cnt_inc   = byte_cnt + CW'(1);
  assign timer_inc = timer + TW'(1);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      timer    <= '0;
      err_flag <= 1'b0;
      wait_cnt <= 1'b0;
      asm_push <= 1'b0;
      asm_data <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      timer    <= timer_nxt;
      err_flag <= err_flag_nxt;
      wait_cnt <= wait_cnt_nxt;
      asm_push <= push_nxt;
      asm_data <= data_nxt;
      if (sync_set) sync_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    timer_nxt    = '0;
    err_flag_nxt = err_flag;
    wait_cnt_nxt = 1'b0;
    push_nxt     = 1'b0;
    data_nxt     = asm_data;
    sync_set     = 1'b0;
    drop         = 1'b0;
    frame_valid  = 1'b0;
    frame_err    = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          push_nxt     = 1'b1;
          data_nxt     = rx_data;
          byte_cnt_nxt = CW'(1);
          state_nxt    = ACCEPT_ST;
        end
      end

      S_COLLECT: begin
        if (rx_valid) begin
          push_nxt     = 1'b1;
          data_nxt     = rx_data;
          byte_cnt_nxt = cnt_inc;
          if (cnt_inc == DEPTH_C) state_nxt = S_WAIT_ASM;
        end else if (timer_inc == TO_LAST) begin
          err_flag_nxt = 1'b1;
          state_nxt    = S_PAD;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      S_PAD: begin
        push_nxt     = 1'b1;
        data_nxt     = PAD_BYTE;
        byte_cnt_nxt = cnt_inc;
        drop         = rx_valid;
        if (cnt_inc == DEPTH_C) state_nxt = S_WAIT_ASM;
      end

      // The assembler reports completion one cycle after the final push lands.
      S_WAIT_ASM: begin
        drop = rx_valid;
        if (asm_valid) begin
          state_nxt = S_HOLD;
        end else if (wait_cnt) begin
          sync_set     = 1'b1;
          err_flag_nxt = 1'b0;
          byte_cnt_nxt = '0;
          state_nxt    = S_IDLE;
        end else begin
          wait_cnt_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        frame_valid = 1'b1;
        frame_err   = err_flag;
        if (frame_ready) begin
          err_flag_nxt = 1'b0;
          byte_cnt_nxt = '0;
          state_nxt    = S_IDLE;
          if (rx_valid) begin
            push_nxt     = 1'b1;
            data_nxt     = rx_data;
            byte_cnt_nxt = CW'(1);
            state_nxt    = ACCEPT_ST;
          end
        end else begin
          drop = rx_valid;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef UART_FRAME_CTRL_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Brief    : Directed self-checking bench for uart_rx_frame_ctrl with a small
//            behavioural frame-assembler model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_frame_ctrl;

  localparam int DEPTH = 4;
`ifdef UART_FRAME_CTRL_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       arst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       asm_push;
  logic [7:0] asm_data;
  logic       asm_valid;
  logic       frame_valid;
  logic       frame_err;
  logic       frame_ready;
  logic       busy;
  logic       sync_err;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;

  // Assembler model: collects DEPTH pushes, pulses asm_valid the cycle after.
  logic       asm_en;
  logic [1:0] m_cnt;
  logic [7:0] m_frame [DEPTH];

  uart_rx_frame_ctrl #(
    .WIDTH(8), .DEPTH(DEPTH), .TIMEOUT(16), .PAD_BYTE(8'h00), .DROP_W(8)
  ) dut (
    .clk(clk), .arst(arst), .rx_valid(rx_valid), .rx_data(rx_data),
    .asm_push(asm_push), .asm_data(asm_data), .asm_valid(asm_valid),
    .frame_valid(frame_valid), .frame_err(frame_err), .frame_ready(frame_ready),
    .busy(busy), .sync_err(sync_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_cnt     <= '0;
      asm_valid <= 1'b0;
    end else begin
      asm_valid <= 1'b0;
      if (asm_push && asm_en) begin
        m_frame[m_cnt] <= asm_data;
        m_cnt          <= m_cnt + 2'd1;
        if (m_cnt == 2'(DEPTH - 1)) asm_valid <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives DEPTH bytes from IDLE; returns in the cycle the last push is visible.
  task automatic send_frame(input logic [31:0] w, input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1'b1;
      rx_data  = w[31-8*i -: 8];
      tick();
      chk({tag, "_push"}, 32'(asm_push), 32'd1);
      chk({tag, "_data"}, 32'(asm_data), 32'(w[31-8*i -: 8]));
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; rx_valid = 1'b0; rx_data = '0; frame_ready = 1'b0; asm_en = 1'b1;
    repeat (3) tick();
    chk("rst_push",  32'(asm_push),    32'd0);
    chk("rst_data",  32'(asm_data),    32'd0);
    chk("rst_fv",    32'(frame_valid), 32'd0);
    chk("rst_fe",    32'(frame_err),   32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_sync",  32'(sync_err),    32'd0);
    chk("rst_drop",  32'(drop_cnt),    32'd0);
    arst = 1'b0;
    tick();

    // Normal frame, consumer always ready
    frame_ready = 1'b1;
    chk("s1_idle_push", 32'(asm_push), 32'd0);
    send_frame(32'h11223344, "s1");
    chk("s1_busy4", 32'(busy), 32'd1);
    tick();
    chk("s1_push5", 32'(asm_push), 32'd0);
    chk("s1_asmv5", 32'(asm_valid), 32'd1);
    chk("s1_fv5", 32'(frame_valid), 32'd0);
    tick();
    chk("s1_fv6", 32'(frame_valid), 32'd1);
    chk("s1_fe6", 32'(frame_err), 32'd0);
    tick();
    chk("s1_busy7", 32'(busy), 32'd0);
    chk("s1_fv7", 32'(frame_valid), 32'd0);
    chk("s1_frame", {m_frame[0], m_frame[1], m_frame[2], m_frame[3]}, 32'h11223344);

    // Timeout padding
    frame_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hAA; tick();
    chk("s2_push_aa", 32'(asm_data), 32'hAA);
    rx_data = 8'hBB; tick();
    chk("s2_push_bb", 32'(asm_data), 32'hBB);
    rx_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("s2_gap", 32'(asm_push), 32'd0);
    end
    tick();
    chk("s2_pad0_push", 32'(asm_push), 32'd1);
    chk("s2_pad0_data", 32'(asm_data), 32'h00);
    tick();
    chk("s2_pad1_push", 32'(asm_push), 32'd1);
    chk("s2_pad1_data", 32'(asm_data), 32'h00);
    tick();
    chk("s2_fv_early", 32'(frame_valid), 32'd0);
    tick();
    chk("s2_fv", 32'(frame_valid), 32'd1);
    chk("s2_fe", 32'(frame_err), 32'd1);
    chk("s2_frame", {m_frame[0], m_frame[1], m_frame[2], m_frame[3]}, 32'hAABB0000);

    // Hold with consumer stalled; bytes arriving meanwhile are dropped
    for (int i = 0; i < 10; i++) begin
      rx_valid = (i == 2 || i == 5 || i == 8);
      rx_data  = 8'(8'hE0 + i);
      tick();
      chk("s3_fv", 32'(frame_valid), 32'd1);
      chk("s3_push", 32'(asm_push), 32'd0);
    end
    rx_valid = 1'b0;
    exp_drop = 3 * DROP_EN;
    chk("s3_drop", 32'(drop_cnt), 32'(exp_drop));
    chk("s3_fe", 32'(frame_err), 32'd1);
    frame_ready = 1'b1;
    tick();
    chk("s3_busy", 32'(busy), 32'd0);
    chk("s3_fv_off", 32'(frame_valid), 32'd0);

    // Byte arriving together with frame_ready starts the next frame
    frame_ready = 1'b0;
    send_frame(32'h01020304, "s4a");
    tick(); tick();
    chk("s4_fv", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    chk("s4_push55", 32'(asm_push), 32'd1);
    chk("s4_data55", 32'(asm_data), 32'h55);
    chk("s4_busy", 32'(busy), 32'd1);
    chk("s4_fv_off", 32'(frame_valid), 32'd0);
    frame_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'(8'h66 + 8'h11 * i);
      tick();
      chk("s4_data", 32'(asm_data), 32'(8'h66 + 8'h11 * i));
    end
    rx_valid = 1'b0;
    tick(); tick();
    chk("s4_fv2", 32'(frame_valid), 32'd1);
    chk("s4_fe2", 32'(frame_err), 32'd0);
    chk("s4_frame", {m_frame[0], m_frame[1], m_frame[2], m_frame[3]}, 32'h55667788);
    chk("s4_drop", 32'(drop_cnt), 32'(exp_drop));
    frame_ready = 1'b1;
    tick();
    chk("s4_busy_end", 32'(busy), 32'd0);

    // Assembler never reports completion
    asm_en = 1'b0;
    send_frame(32'hA1A2A3A4, "s5");
    chk("s5_sync_w1", 32'(sync_err), 32'd0);
    tick();
    chk("s5_busy_w2", 32'(busy), 32'd1);
    chk("s5_sync_w2", 32'(sync_err), 32'd0);
    tick();
    chk("s5_sync", 32'(sync_err), 32'd1);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_fv", 32'(frame_valid), 32'd0);
    tick();
    chk("s5_sync_sticky", 32'(sync_err), 32'd1);

    // Asynchronous reset mid-frame
    rx_valid = 1'b1; rx_data = 8'h99; tick();
    chk("s6_push99", 32'(asm_data), 32'h99);
    rx_data = 8'h9A; tick();
    chk("s6_push9a", 32'(asm_push), 32'd1);
    chk("s6_busy_pre", 32'(busy), 32'd1);
    rx_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("s6_rst_push", 32'(asm_push), 32'd0);
    chk("s6_rst_data", 32'(asm_data), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    chk("s6_rst_sync", 32'(sync_err), 32'd0);
    chk("s6_rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    arst = 1'b0; asm_en = 1'b1;
    send_frame(32'hC1C2C3C4, "s6");
    tick(); tick();
    chk("s6_fv", 32'(frame_valid), 32'd1);
    chk("s6_fe", 32'(frame_err), 32'd0);
    chk("s6_frame", {m_frame[0], m_frame[1], m_frame[2], m_frame[3]}, 32'hC1C2C3C4);
    tick();
    chk("s6_busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
